// File: rtl/ex_pkg.sv
// ex_pkg: shared EX-stage definitions.
//   - Result-select encodings driven by decode into ex_result_sel.
//   - Payload layout carried from EX to MEM (default core widths).
//   - State encoding of the two-entry skid buffer.
package ex_pkg;

    localparam logic [1:0] RES_ALU   = 2'd0;
    localparam logic [1:0] RES_IMM   = 2'd1;
    localparam logic [1:0] RES_PC4   = 2'd2;
    localparam logic [1:0] RES_PCIMM = 2'd3;

    localparam int EX_XLEN    = 32;
    localparam int EX_RADDR_W = 5;

    // EX/MEM payload at the default core configuration. The stage itself
    // re-declares the same field order at its own parameter widths.
    typedef struct packed {
        logic [EX_RADDR_W-1:0] regWAddr;
        logic                  regWEn;
        logic [EX_XLEN-1:0]    regRData2;
        logic [EX_XLEN-1:0]    result;
        logic [EX_XLEN-1:0]    pc;
    } ex_mem_t;

    typedef enum logic [1:0] {
        SK_EMPTY = 2'd0,
        SK_ONE   = 2'd1,
        SK_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic two-entry skid buffer.
//   Ports:
//     clk, reset (async, active-high), flush (sync, drops everything)
//     in_valid / in_ready / in_data   : upstream handshake; in_ready is a flop
//     out_valid / out_ready / out_data: downstream handshake; head entry
//   Every output is a flop. Empty slots hold zero, so out_data is zero
//   whenever out_valid is low.
module pipe_skid_buf
    import ex_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, out_valid_q;
    logic         accept, fire;

    // in_ready_q only depends on state, never on out_ready, so there is
    // no combinational path from MEM back into EX.
    assign accept = in_valid & in_ready_q & ~flush;
    assign fire   = out_valid_q & out_ready;

    always_comb begin
        state_d = state;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Flush beats any same-cycle fire or accept.
            state_d = SK_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state)
                SK_EMPTY: begin
                    if (accept) begin
                        state_d = SK_ONE;
                        main_d  = in_data;
                    end
                end
                SK_ONE: begin
                    if (accept && !fire) begin
                        state_d = SK_FULL;
                        skid_d  = in_data;
                    end else if (accept && fire) begin
                        main_d  = in_data;
                    end else if (fire) begin
                        state_d = SK_EMPTY;
                        main_d  = '0;
                    end
                end
                SK_FULL: begin
                    if (fire) begin
                        state_d = SK_ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = SK_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SK_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != SK_FULL);
            out_valid_q <= (state_d != SK_EMPTY);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: EX/MEM pipeline stage.
//   Selects the EX result (ALU / imm / pc+PC_STEP / pc+imm), then carries
//   result, store data, destination register and PC to MEM through a
//   two-entry skid buffer. A forwarding tap exposes the head entry.
//   Ports:
//     clk, reset (async, active-high), flush (sync)
//     in_*: EX entry + handshake; ex_result_sel/in_imm/alu_result feed the mux
//     out_*: head-entry payload + handshake to MEM
//     fwd_*: forwarding tap from the head entry
module ex_mem_skid
    import ex_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int PC_STEP = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RADDR_W-1:0] in_regWAddr,
    input  logic               in_regWEn,
    input  logic [XLEN-1:0]    in_regRData2,
    input  logic [1:0]         ex_result_sel,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [XLEN-1:0]    alu_result,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RADDR_W-1:0] out_regWAddr,
    output logic               out_regWEn,
    output logic [XLEN-1:0]    out_regRData2,
    output logic [XLEN-1:0]    out_result,
    output logic [XLEN-1:0]    out_pc,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_addr,
    output logic [XLEN-1:0]    fwd_data
);

    // Same field order as ex_pkg::ex_mem_t, plus a precomputed forwarding
    // flag so fwd_valid is a plain flop bit instead of logic on the outputs.
    // The flag is zero in empty slots, which keeps fwd_valid low with out_valid.
    typedef struct packed {
        logic [RADDR_W-1:0] regWAddr;
        logic               regWEn;
        logic [XLEN-1:0]    regRData2;
        logic [XLEN-1:0]    result;
        logic [XLEN-1:0]    pc;
        logic               fwd;
    } stage_t;

    localparam int PW = $bits(stage_t);

    logic [XLEN-1:0] result;
    stage_t          in_entry, head;

    // Sums wrap modulo 2^XLEN; carry is dropped.
    always_comb begin
        result = alu_result;
        unique case (ex_result_sel)
            RES_ALU:   result = alu_result;
            RES_IMM:   result = in_imm;
            RES_PC4:   result = in_pc + XLEN'(PC_STEP);
            RES_PCIMM: result = in_pc + in_imm;
            default:   result = alu_result;
        endcase
    end

    always_comb begin
        in_entry.regWAddr  = in_regWAddr;
        in_entry.regWEn    = in_regWEn;
        in_entry.regRData2 = in_regRData2;
        in_entry.result    = result;
        in_entry.pc        = in_pc;
        in_entry.fwd       = in_regWEn & (in_regWAddr != '0);
    end

    pipe_skid_buf #(.W(PW)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_regWAddr  = head.regWAddr;
    assign out_regWEn    = head.regWEn;
    assign out_regRData2 = head.regRData2;
    assign out_result    = head.result;
    assign out_pc        = head.pc;

    assign fwd_valid = head.fwd;
    assign fwd_addr  = head.regWAddr;
    assign fwd_data  = head.result;

endmodule

// File: tb/tb_ex_mem_skid.sv
module tb_ex_mem_skid;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_regWAddr = '0;
    logic        in_regWEn = 1'b0;
    logic [31:0] in_regRData2 = '0;
    logic [1:0]  ex_result_sel = '0;
    logic [31:0] in_imm = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_regWAddr;
    logic        out_regWEn;
    logic [31:0] out_regRData2;
    logic [31:0] out_result;
    logic [31:0] out_pc;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  a;
        logic        w;
        logic [31:0] d;
        logic [31:0] r;
        logic [31:0] p;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    ex_mem_skid #(.XLEN(32), .RADDR_W(5), .PC_STEP(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regWAddr(in_regWAddr), .in_regWEn(in_regWEn), .in_regRData2(in_regRData2),
        .ex_result_sel(ex_result_sel), .in_imm(in_imm), .alu_result(alu_result), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_regWAddr(out_regWAddr), .out_regWEn(out_regWEn), .out_regRData2(out_regRData2),
        .out_result(out_result), .out_pc(out_pc),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare each entry MEM takes against the scoreboard, and
    // check that idle outputs are zero.
    always @(negedge clk) begin
        if (!reset && !flush) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_entry", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_result", out_result, e.r);
                    chk("sb_addr", 32'(out_regWAddr), 32'(e.a));
                    chk("sb_wen", 32'(out_regWEn), 32'(e.w));
                    chk("sb_rdata2", out_regRData2, e.d);
                    chk("sb_pc", out_pc, e.p);
                    chk("sb_fwd_valid", 32'(fwd_valid), 32'(e.w && (e.a != 5'd0)));
                end
            end else if (!out_valid) begin
                chk("idle_zero", out_result | out_pc | out_regRData2 | 32'(out_regWAddr)
                    | 32'(out_regWEn) | 32'(fwd_valid), 32'd0);
            end
        end
    end

    task automatic drive(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [31:0] rd2,
                         input logic [4:0] a, input logic w);
        ex_result_sel = sel; alu_result = alu; in_imm = imm; in_pc = pc;
        in_regRData2 = rd2; in_regWAddr = a; in_regWEn = w; in_valid = 1'b1;
    endtask

    // Offer one entry; push its hand-computed expectation once it is accepted.
    task automatic send(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [31:0] rd2,
                        input logic [4:0] a, input logic w, input logic [31:0] exp_res);
        int n;
        exp_t e;
        drive(sel, alu, imm, pc, rd2, a, w);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'd1, 32'd0);
        end else begin
            e.a = a; e.w = w; e.d = rd2; e.r = exp_res; e.p = pc;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid_after", 32'(out_valid), 32'd0);

        // Basic pass-through with forwarding tap
        out_ready = 1'b1;
        send(2'd0, 32'h0000_1234, 32'h0, 32'h0000_0040, 32'h5555_0000, 5'd5, 1'b1, 32'h0000_1234);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_out_result", out_result, 32'h0000_1234);
        chk("lat_fwd_valid", 32'(fwd_valid), 32'd1);
        chk("lat_fwd_addr", 32'(fwd_addr), 32'd5);
        chk("lat_fwd_data", fwd_data, 32'h0000_1234);

        // Result selects with PC wrap
        send(2'd1, 32'hDEAD_BEEF, 32'h10, 32'hFFFF_FFFC, 32'h1, 5'd6, 1'b1, 32'h0000_0010);
        send(2'd2, 32'hDEAD_BEEF, 32'h10, 32'hFFFF_FFFC, 32'h2, 5'd7, 1'b1, 32'h0000_0000);
        send(2'd3, 32'hDEAD_BEEF, 32'h10, 32'hFFFF_FFFC, 32'h3, 5'd8, 1'b1, 32'h0000_000C);
        drain();

        // Back-pressure: A in main, B in skid, C held
        out_ready = 1'b0;
        send(2'd0, 32'hAAAA_0001, 32'h0, 32'h0000_0100, 32'hA, 5'd1, 1'b1, 32'hAAAA_0001);
        send(2'd3, 32'h0, 32'h20, 32'h0000_0100, 32'hB, 5'd2, 1'b1, 32'h0000_0120);
        drive(2'd2, 32'h0, 32'h0, 32'h0000_0200, 32'hC, 5'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_head", out_result, 32'hAAAA_0001);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(2'd2, 32'h0, 32'h0, 32'h0000_0200, 32'hC, 5'd3, 1'b0, 32'h0000_0204);
        drain();

        // Flush while FULL with an entry offered
        out_ready = 1'b0;
        send(2'd0, 32'h0D0D_0D0D, 32'h0, 32'h300, 32'hD, 5'd9, 1'b1, 32'h0D0D_0D0D);
        send(2'd0, 32'h0E0E_0E0E, 32'h0, 32'h304, 32'hE, 5'd10, 1'b1, 32'h0E0E_0E0E);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        drive(2'd0, 32'h0F0F_0F0F, 32'h0, 32'h308, 32'hF, 5'd11, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        q.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_out_result", out_result, 32'd0);
        chk("flush_out_pc", out_pc, 32'd0);
        chk("flush_out_addr", 32'(out_regWAddr), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_fwd_valid", 32'(fwd_valid), 32'd0);
        @(posedge clk); #1;
        chk("flush_dropped", 32'(out_valid), 32'd0);

        // x0 destination never forwards
        out_ready = 1'b1;
        send(2'd0, 32'h7777_0000, 32'h0, 32'h400, 32'h7, 5'd0, 1'b1, 32'h7777_0000);
        chk("x0_out_valid", 32'(out_valid), 32'd1);
        chk("x0_fwd_valid", 32'(fwd_valid), 32'd0);
        drain();

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        send(2'd1, 32'h0, 32'h1111_1111, 32'h500, 32'h1, 5'd12, 1'b1, 32'h1111_1111);
        send(2'd1, 32'h0, 32'h2222_2222, 32'h504, 32'h2, 5'd13, 1'b1, 32'h2222_2222);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        #3;
        reset = 1'b1;
        #1;
        q.delete();
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_result", out_result, 32'd0);
        chk("arst_out_pc", out_pc, 32'd0);
        chk("arst_fwd_valid", 32'(fwd_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid_after", 32'(out_valid), 32'd0);

        chk("sb_empty_end", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
